// File: rtl/eee_msg_reader.sv
// eee_msg_reader
//   Avalon-MM master that drains the vision pipeline's message FIFO through
//   the image processor's slave port. It polls the status register. Once at
//   least MSG_WORDS words are buffered, it reads one 3-word bounding-box
//   message: an "RBB" header, the top-left word and the bottom-right word.
//   It then publishes the decoded box. If the header does not match, it
//   flushes the remote FIFO to resynchronise.
//
// Ports
//   clk, reset_n       system clock, asynchronous active-low reset
//   enable             level; 0 lets a message in progress finish, then idles
//   m_chipselect       asserted together with m_read or m_write
//   m_read / m_write   single-cycle access pulses, always followed by an idle cycle
//   m_address          0 = status, 1 = message word
//   m_writedata        flush word (status bit 4)
//   m_readdata         registered slave data, valid the cycle after m_read
//   bb_x/y_min/max     published box coordinates (unsigned 11-bit)
//   bb_valid           1-cycle strobe when new coordinates are published
//   bb_present         box is non-empty (min <= max on both axes)
//   msg_count          messages decoded (wrapping)
//   err_count          header mismatches (saturating)

module eee_msg_reader #(
  parameter int unsigned POLL_INTERVAL = 16,
  parameter logic [31:0] MSG_ID        = 32'h00524242,
  parameter int unsigned MSG_WORDS     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic [10:0] bb_x_min,
  output logic [10:0] bb_y_min,
  output logic [10:0] bb_x_max,
  output logic [10:0] bb_y_max,
  output logic        bb_valid,
  output logic        bb_present,
  output logic [15:0] msg_count,
  output logic [7:0]  err_count
);

  localparam int unsigned   CW     = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(POLL_INTERVAL - 1);

  localparam logic [2:0]  ADDR_STATUS = 3'd0;
  localparam logic [2:0]  ADDR_MSG    = 3'd1;
  localparam logic [31:0] FLUSH_WORD  = 32'h0000_0010;

  typedef enum logic [3:0] {
    S_WAIT, S_ST_RD, S_ST_CAP, S_HD_RD, S_HD_CAP, S_FL_WR,
    S_TL_RD, S_TL_CAP, S_BR_RD, S_BR_CAP, S_PUB
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;

  // Top-left shadow: holds the first coordinate word until the whole message is in.
  logic [10:0] x_min_sh_reg, y_min_sh_reg;

  logic [10:0] bb_x_min_reg, bb_y_min_reg, bb_x_max_reg, bb_y_max_reg;
  logic        bb_present_reg;
  logic [15:0] msg_count_reg;
  logic [7:0]  err_count_reg;

  // Decoded views of the captured slave word. Bits [31:27] and [15:11] are ignored.
  logic [7:0]  usedw;
  logic [10:0] word_hi, word_lo;
  logic        hdr_ok;

  assign usedw   = m_readdata[15:8];
  assign word_hi = m_readdata[26:16];
  assign word_lo = m_readdata[10:0];
  assign hdr_ok  = (m_readdata == MSG_ID);

  // Next-state logic and bus strobes. Every access state is followed by a
  // capture or idle state, so back-to-back accesses cannot occur.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    m_chipselect  = 1'b0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_address     = ADDR_STATUS;
    m_writedata   = 32'h0;

    case (state_reg)
      S_WAIT: begin
        if (wait_cnt_reg == '0) begin
          if (enable) begin
            state_next = S_ST_RD;
          end else begin
            wait_cnt_next = RELOAD;
          end
        end else begin
          wait_cnt_next = wait_cnt_reg - 1'b1;
        end
      end
      S_ST_RD: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = ADDR_STATUS;
        state_next   = S_ST_CAP;
      end
      S_ST_CAP: begin
        if (32'(usedw) >= MSG_WORDS) begin
          state_next = S_HD_RD;
        end else begin
          state_next    = S_WAIT;
          wait_cnt_next = RELOAD;
        end
      end
      S_HD_RD: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = ADDR_MSG;
        state_next   = S_HD_CAP;
      end
      S_HD_CAP: begin
        state_next = hdr_ok ? S_TL_RD : S_FL_WR;
      end
      S_FL_WR: begin
        m_chipselect  = 1'b1;
        m_write       = 1'b1;
        m_address     = ADDR_STATUS;
        m_writedata   = FLUSH_WORD;
        state_next    = S_WAIT;
        wait_cnt_next = RELOAD;
      end
      S_TL_RD: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = ADDR_MSG;
        state_next   = S_TL_CAP;
      end
      S_TL_CAP: begin
        state_next = S_BR_RD;
      end
      S_BR_RD: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_address    = ADDR_MSG;
        state_next   = S_BR_CAP;
      end
      S_BR_CAP: begin
        state_next = S_PUB;
      end
      S_PUB: begin
        // Re-poll immediately: more messages are likely queued behind this one.
        if (enable) begin
          state_next = S_ST_RD;
        end else begin
          state_next    = S_WAIT;
          wait_cnt_next = RELOAD;
        end
      end
      default: begin
        state_next    = S_WAIT;
        wait_cnt_next = RELOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_WAIT;
      wait_cnt_reg   <= RELOAD;
      x_min_sh_reg   <= 11'h7FF;
      y_min_sh_reg   <= 11'h7FF;
      bb_x_min_reg   <= 11'h7FF;
      bb_y_min_reg   <= 11'h7FF;
      bb_x_max_reg   <= 11'h000;
      bb_y_max_reg   <= 11'h000;
      bb_present_reg <= 1'b0;
      msg_count_reg  <= 16'h0;
      err_count_reg  <= 8'h0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;

      case (state_reg)
        S_HD_CAP: begin
          if (!hdr_ok && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
          end
        end
        S_TL_CAP: begin
          x_min_sh_reg <= word_hi;
          y_min_sh_reg <= word_lo;
        end
        S_BR_CAP: begin
          // The publish registers load on the edge into PUB, so the new box,
          // bb_present and msg_count are visible in the same cycle as bb_valid.
          // The bottom-right word goes straight from the bus into the outputs.
          bb_x_min_reg   <= x_min_sh_reg;
          bb_y_min_reg   <= y_min_sh_reg;
          bb_x_max_reg   <= word_hi;
          bb_y_max_reg   <= word_lo;
          bb_present_reg <= (x_min_sh_reg <= word_hi) && (y_min_sh_reg <= word_lo);
          msg_count_reg  <= msg_count_reg + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bb_valid   = (state_reg == S_PUB);
  assign bb_x_min   = bb_x_min_reg;
  assign bb_y_min   = bb_y_min_reg;
  assign bb_x_max   = bb_x_max_reg;
  assign bb_y_max   = bb_y_max_reg;
  assign bb_present = bb_present_reg;
  assign msg_count  = msg_count_reg;
  assign err_count  = err_count_reg;

endmodule

// File: tb/tb_eee_msg_reader.sv
// Testbench for eee_msg_reader: directed scenarios against a small FIFO slave model.
`timescale 1ns/1ps

module tb_eee_msg_reader;

  localparam int          P  = 16;
  localparam logic [31:0] ID = 32'h00524242;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        m_chipselect, m_read, m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = 32'hA5A5_A5A5;
  logic [10:0] bb_x_min, bb_y_min, bb_x_max, bb_y_max;
  logic        bb_valid, bb_present;
  logic [15:0] msg_count;
  logic [7:0]  err_count;

  eee_msg_reader #(.POLL_INTERVAL(P), .MSG_ID(ID), .MSG_WORDS(3)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .bb_x_min(bb_x_min), .bb_y_min(bb_y_min), .bb_x_max(bb_x_max), .bb_y_max(bb_y_max),
    .bb_valid(bb_valid), .bb_present(bb_present),
    .msg_count(msg_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] data;
    int          cyc;
    int          prev_rd0;
  } acc_t;

  acc_t        acc_q[$];
  logic [31:0] fifo[$];
  int          valid_q[$];
  int cyc = 0, last_acc = -10, last_rd0 = -1;
  int b2b_viol = 0, proto_viol = 0;
  int n_acc = 0, n_rd1 = 0, n_wr = 0, n_valid = 0;
  int tests_run = 0, tests_failed = 0;

  // Slave: registered read data valid exactly one cycle after the read pulse,
  // junk otherwise, so a capture in the wrong cycle is visible.
  always @(posedge clk) begin
    if (m_chipselect && m_read) begin
      if (m_address == 3'd0)
        m_readdata <= {16'h0, 8'(fifo.size()), 8'h00};
      else if (fifo.size() > 0)
        m_readdata <= fifo.pop_front();
      else
        m_readdata <= 32'hDEAD_BEEF;
    end else begin
      m_readdata <= 32'hA5A5_A5A5;
    end
    if (m_chipselect && m_write && m_address == 3'd0 && m_writedata[4])
      fifo.delete();
  end

  // Bus and strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if ((m_read || m_write) && !m_chipselect) proto_viol <= proto_viol + 1;
    if (m_chipselect && !(m_read ^ m_write)) proto_viol <= proto_viol + 1;
    if (m_chipselect && (m_read || m_write)) begin
      if ((cyc + 1) - last_acc < 2) b2b_viol <= b2b_viol + 1;
      last_acc <= cyc + 1;
      n_acc <= n_acc + 1;
      acc_q.push_back('{m_write, m_address, m_writedata, cyc + 1, last_rd0});
      if (m_read && m_address == 3'd0) last_rd0 <= cyc + 1;
      if (m_read && m_address == 3'd1) n_rd1 <= n_rd1 + 1;
      if (m_write) n_wr <= n_wr + 1;
      if (m_write)
        $display("[TB] cyc %0d WR addr=%0d data=%h", cyc + 1, m_address, m_writedata);
      else
        $display("[TB] cyc %0d RD addr=%0d", cyc + 1, m_address);
    end
    if (bb_valid) begin
      n_valid <= n_valid + 1;
      valid_q.push_back(cyc + 1);
      $display("[TB] cyc %0d BB (%0d,%0d)-(%0d,%0d) present=%0b msgs=%0d",
               cyc + 1, bb_x_min, bb_y_min, bb_x_max, bb_y_max, bb_present, msg_count);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_valid(input int target, input int limit);
    int t = 0;
    while (n_valid < target && t < limit) begin tick(); t++; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0;
    ticks(3);
    tests_run++; if ({m_chipselect, m_read, m_write} !== 3'b000) begin tests_failed++; $display("FAIL reset_bus: got %b expected 000", {m_chipselect, m_read, m_write}); end
    tests_run++; if (bb_x_min !== 11'h7FF || bb_y_min !== 11'h7FF) begin tests_failed++; $display("FAIL reset_min: got %h,%h expected 7ff,7ff", bb_x_min, bb_y_min); end
    tests_run++; if (bb_x_max !== 11'h0 || bb_y_max !== 11'h0) begin tests_failed++; $display("FAIL reset_max: got %h,%h expected 0,0", bb_x_max, bb_y_max); end
    tests_run++; if ({bb_valid, bb_present} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got %b expected 00", {bb_valid, bb_present}); end
    tests_run++; if (msg_count !== 16'h0 || err_count !== 8'h0) begin tests_failed++; $display("FAIL reset_counts: got %h,%h expected 0,0", msg_count, err_count); end
    enable = 1'b1;
    ticks(2);
    tests_run++; if (n_acc !== 0) begin tests_failed++; $display("FAIL reset_no_access: got %0d expected 0", n_acc); end
    reset_n = 1'b1;
  endtask

  task automatic test_idle_poll();
    int r = cyc;
    int bad = 0, gaps = 0;
    acc_q.delete();
    ticks(5 * (P + 2) + P);
    foreach (acc_q[i]) begin
      if (acc_q[i].wr || acc_q[i].addr != 3'd0) bad++;
      if (i > 0 && acc_q[i].cyc - acc_q[i-1].cyc != P + 2) gaps++;
    end
    tests_run++; if (acc_q.size() != 6) begin tests_failed++; $display("FAIL idle_poll_count: got %0d expected 6", acc_q.size()); end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL idle_addr0_only: got %0d other accesses expected 0", bad); end
    tests_run++; if (gaps != 0) begin tests_failed++; $display("FAIL idle_spacing: got %0d wrong gaps expected 0", gaps); end
    if (acc_q.size() > 0) begin
      tests_run++; if (acc_q[0].cyc - r != P) begin tests_failed++; $display("FAIL first_poll_delay: got %0d expected %0d", acc_q[0].cyc - r, P); end
    end
  endtask

  task automatic test_message();
    int v0 = n_valid;
    int rd1 = 0, lat = -1, after = -1, vc = -1;
    acc_q.delete();
    fifo.push_back(ID);
    fifo.push_back({5'b0, 11'd100, 5'b0, 11'd50});
    fifo.push_back({5'b0, 11'd200, 5'b0, 11'd120});
    wait_valid(v0 + 1, 200);
    ticks(3);
    if (valid_q.size() > 0) vc = valid_q[valid_q.size()-1];
    foreach (acc_q[i]) begin
      if (!acc_q[i].wr && acc_q[i].addr == 3'd1) begin
        if (rd1 == 0) lat = vc - acc_q[i].prev_rd0;
        rd1++;
      end
      if (after < 0 && acc_q[i].cyc > vc) after = acc_q[i].cyc - vc + (acc_q[i].addr == 3'd0 && !acc_q[i].wr ? 0 : 100);
    end
    tests_run++; if (n_valid - v0 != 1) begin tests_failed++; $display("FAIL msg_valid_cycles: got %0d expected 1", n_valid - v0); end
    tests_run++; if ({bb_x_min, bb_y_min} !== {11'd100, 11'd50}) begin tests_failed++; $display("FAIL msg_tl: got %0d,%0d expected 100,50", bb_x_min, bb_y_min); end
    tests_run++; if ({bb_x_max, bb_y_max} !== {11'd200, 11'd120}) begin tests_failed++; $display("FAIL msg_br: got %0d,%0d expected 200,120", bb_x_max, bb_y_max); end
    tests_run++; if (bb_present !== 1'b1 || bb_valid !== 1'b0) begin tests_failed++; $display("FAIL msg_flags: got present=%b valid=%b expected 1,0", bb_present, bb_valid); end
    tests_run++; if (msg_count !== 16'd1) begin tests_failed++; $display("FAIL msg_count: got %0d expected 1", msg_count); end
    tests_run++; if (rd1 != 3) begin tests_failed++; $display("FAIL msg_addr1_reads: got %0d expected 3", rd1); end
    tests_run++; if (lat != 8) begin tests_failed++; $display("FAIL msg_latency: got %0d expected 8", lat); end
    tests_run++; if (after != 1) begin tests_failed++; $display("FAIL msg_repoll: got %0d expected 1", after); end
    tests_run++; if (b2b_viol != 0) begin tests_failed++; $display("FAIL msg_idle_gap: got %0d back-to-back expected 0", b2b_viol); end
  endtask

  task automatic test_empty_frame();
    int v0 = n_valid;
    int vis = 0;
    fifo.push_back(ID);
    fifo.push_back({5'b0, 11'd639, 5'b0, 11'd479});
    fifo.push_back(32'h0);
    wait_valid(v0 + 1, 200);
    vis = n_valid - v0;
    tests_run++; if (vis != 1) begin tests_failed++; $display("FAIL empty_valid: got %0d expected 1", vis); end
    tests_run++; if (bb_present !== 1'b0) begin tests_failed++; $display("FAIL empty_present: got %b expected 0", bb_present); end
    tests_run++; if ({bb_x_min, bb_y_min, bb_x_max, bb_y_max} !== {11'd639, 11'd479, 11'd0, 11'd0}) begin tests_failed++; $display("FAIL empty_coords: got %0d,%0d,%0d,%0d expected 639,479,0,0", bb_x_min, bb_y_min, bb_x_max, bb_y_max); end
    tests_run++; if (msg_count !== 16'd2) begin tests_failed++; $display("FAIL empty_msg_count: got %0d expected 2", msg_count); end
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    int gap = -1;
    // Ignored bits [31:27]/[15:11] set to catch field masking errors.
    fifo.push_back(ID);
    fifo.push_back({5'h1F, 11'd10, 5'h1F, 11'd20});
    fifo.push_back({5'h10, 11'd30, 5'h01, 11'd40});
    fifo.push_back(ID);
    fifo.push_back({5'h1F, 11'd300, 5'h15, 11'd200});
    fifo.push_back({5'h0A, 11'd310, 5'h1F, 11'd210});
    wait_valid(v0 + 2, 300);
    tick();
    if (valid_q.size() >= 2) gap = valid_q[valid_q.size()-1] - valid_q[valid_q.size()-2];
    tests_run++; if (msg_count !== 16'd4) begin tests_failed++; $display("FAIL b2b_msg_count: got %0d expected 4", msg_count); end
    tests_run++; if ({bb_x_min, bb_y_min, bb_x_max, bb_y_max} !== {11'd300, 11'd200, 11'd310, 11'd210}) begin tests_failed++; $display("FAIL b2b_coords: got %0d,%0d,%0d,%0d expected 300,200,310,210", bb_x_min, bb_y_min, bb_x_max, bb_y_max); end
    tests_run++; if (bb_present !== 1'b1) begin tests_failed++; $display("FAIL b2b_present: got %b expected 1", bb_present); end
    tests_run++; if (gap != 9) begin tests_failed++; $display("FAIL b2b_strobe_gap: got %0d expected 9", gap); end
    tests_run++; if (b2b_viol != 0 || proto_viol != 0) begin tests_failed++; $display("FAIL b2b_protocol: got %0d,%0d violations expected 0,0", b2b_viol, proto_viol); end
  endtask

  task automatic test_enable_drop();
    int v0 = n_valid;
    int r0 = n_rd1;
    int a0, t = 0;
    enable = 1'b1;
    fifo.push_back(ID);
    fifo.push_back({5'b0, 11'd5, 5'b0, 11'd6});
    fifo.push_back({5'b0, 11'd7, 5'b0, 11'd8});
    while (n_rd1 == r0 && t < 100) begin tick(); t++; end
    tick();
    enable = 1'b0;
    wait_valid(v0 + 1, 50);
    tick();
    tests_run++; if (n_valid - v0 != 1) begin tests_failed++; $display("FAIL en_drop_valid: got %0d expected 1", n_valid - v0); end
    tests_run++; if ({bb_x_min, bb_y_min, bb_x_max, bb_y_max} !== {11'd5, 11'd6, 11'd7, 11'd8}) begin tests_failed++; $display("FAIL en_drop_coords: got %0d,%0d,%0d,%0d expected 5,6,7,8", bb_x_min, bb_y_min, bb_x_max, bb_y_max); end
    tests_run++; if (msg_count !== 16'd5) begin tests_failed++; $display("FAIL en_drop_msg_count: got %0d expected 5", msg_count); end
    a0 = n_acc;
    ticks(3 * (P + 2));
    tests_run++; if (n_acc != a0) begin tests_failed++; $display("FAIL en_drop_idle: got %0d accesses expected 0", n_acc - a0); end
    enable = 1'b1;
  endtask

  task automatic test_bad_header();
    int v0 = n_valid;
    int w0 = n_wr;
    int t = 0;
    acc_q.delete();
    fifo.push_back(32'h1234_5678);
    fifo.push_back(32'h1111_1111);
    fifo.push_back(32'h2222_2222);
    while (n_wr == w0 && t < 100) begin tick(); t++; end
    tick();
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("FAIL bad_hdr_err_count: got %0d expected 1", err_count); end
    tests_run++; if (n_valid != v0 || msg_count !== 16'd5) begin tests_failed++; $display("FAIL bad_hdr_no_publish: got %0d strobes msgs=%0d expected 0,5", n_valid - v0, msg_count); end
    tests_run++; if (fifo.size() != 0) begin tests_failed++; $display("FAIL bad_hdr_flushed: got %0d words expected 0", fifo.size()); end
    if (acc_q.size() >= 2) begin
      tests_run++; if (!acc_q[acc_q.size()-1].wr || acc_q[acc_q.size()-1].addr != 3'd0 || acc_q[acc_q.size()-1].data !== 32'h10) begin tests_failed++; $display("FAIL bad_hdr_flush_write: got wr=%0b addr=%0d data=%h expected 1,0,00000010", acc_q[acc_q.size()-1].wr, acc_q[acc_q.size()-1].addr, acc_q[acc_q.size()-1].data); end
      tests_run++; if (acc_q[acc_q.size()-2].wr || acc_q[acc_q.size()-2].addr != 3'd1 || acc_q[acc_q.size()-1].cyc - acc_q[acc_q.size()-2].cyc != 2) begin tests_failed++; $display("FAIL bad_hdr_sequence: got prev addr=%0d gap=%0d expected 1,2", acc_q[acc_q.size()-2].addr, acc_q[acc_q.size()-1].cyc - acc_q[acc_q.size()-2].cyc); end
    end else begin
      tests_run++; tests_failed++; $display("FAIL bad_hdr_accesses: got %0d expected >=2", acc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int r0 = n_rd1;
    int t = 0, r;
    enable = 1'b1;
    fifo.push_back(ID);
    fifo.push_back({5'b0, 11'd1, 5'b0, 11'd2});
    fifo.push_back({5'b0, 11'd3, 5'b0, 11'd4});
    while (n_rd1 < r0 + 2 && t < 200) begin tick(); t++; end
    tick();   // now in TL_CAP
    #1 reset_n = 1'b0;
    #1;
    tests_run++; if ({bb_x_min, bb_y_min, bb_x_max, bb_y_max} !== {11'h7FF, 11'h7FF, 11'h0, 11'h0}) begin tests_failed++; $display("FAIL rst_mid_coords: got %h,%h,%h,%h expected 7ff,7ff,0,0", bb_x_min, bb_y_min, bb_x_max, bb_y_max); end
    tests_run++; if (msg_count !== 16'h0 || err_count !== 8'h0 || bb_present !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_counts: got %0d,%0d,%b expected 0,0,0", msg_count, err_count, bb_present); end
    ticks(2);
    reset_n = 1'b1;
    r = cyc;
    acc_q.delete();
    t = 0;
    while (acc_q.size() == 0 && t < 100) begin tick(); t++; end
    if (acc_q.size() > 0) begin
      tests_run++; if (acc_q[0].wr || acc_q[0].addr != 3'd0 || acc_q[0].cyc - r != P) begin tests_failed++; $display("FAIL rst_mid_first_poll: got wr=%0b addr=%0d delay=%0d expected 0,0,%0d", acc_q[0].wr, acc_q[0].addr, acc_q[0].cyc - r, P); end
    end else begin
      tests_run++; tests_failed++; $display("FAIL rst_mid_first_poll: got no access expected status poll");
    end
    tests_run++; if (fifo.size() != 1) begin tests_failed++; $display("FAIL rst_mid_leftover: got %0d words expected 1", fifo.size()); end
  endtask

  task automatic test_err_saturate();
    int timeouts = 0;
    int w0, t;
    // The leftover bottom-right word plus two more becomes a bad "header".
    for (int i = 0; i < 257; i++) begin
      if (i == 0) begin
        fifo.push_back(32'h0);
        fifo.push_back(32'h0);
      end else begin
        fifo.push_back(32'hBAD0_0000 + i);
        fifo.push_back(32'h0);
        fifo.push_back(32'h0);
      end
      w0 = n_wr; t = 0;
      while (n_wr == w0 && t < 100) begin tick(); t++; end
      if (n_wr == w0) begin timeouts++; break; end
      tick();
      if (i == 0) begin
        tests_run++; if (err_count !== 8'd1 || fifo.size() != 0) begin tests_failed++; $display("FAIL resync_flush: got err=%0d words=%0d expected 1,0", err_count, fifo.size()); end
      end
      if (i == 255) begin
        tests_run++; if (err_count !== 8'hFF) begin tests_failed++; $display("FAIL err_256: got %h expected ff", err_count); end
      end
    end
    tests_run++; if (timeouts != 0) begin tests_failed++; $display("FAIL sat_timeout: got %0d timeouts expected 0", timeouts); end
    tests_run++; if (err_count !== 8'hFF) begin tests_failed++; $display("FAIL err_saturate: got %h expected ff", err_count); end
    tests_run++; if (msg_count !== 16'd0 || b2b_viol != 0 || proto_viol != 0) begin tests_failed++; $display("FAIL sat_side_effects: got msgs=%0d b2b=%0d proto=%0d expected 0,0,0", msg_count, b2b_viol, proto_viol); end
  endtask

  initial begin
    test_reset();
    test_idle_poll();
    test_message();
    test_empty_frame();
    test_back_to_back();
    test_enable_drop();
    test_bad_header();
    test_reset_mid();
    test_err_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/eee_msg_reader.md
Name: eee_msg_reader

Overview:
Avalon-MM master that drains the vision pipeline's message FIFO through the image processor's slave port, so software does not have to poll it. It polls the status register, reads complete 3-word bounding-box messages ("RBB" header, top-left, bottom-right) and decodes them. It presents the latest box as registered coordinates with a one-cycle update strobe for the drive/control logic.
On a header mismatch it flushes the remote FIFO to resynchronise.

Parameters:
POLL_INTERVAL, 16, idle cycles between status polls when fewer than 3 words are buffered (minimum 1)
MSG_ID, 32'h00524242, expected header word ("RBB")
MSG_WORDS, 3, words per message; a message read starts only when usedw >= MSG_WORDS

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  level; when 0, the block finishes any message in progress and then idles
m_chipselect  out  1  asserted with m_read or m_write
m_read  out  1  single-cycle read pulse
m_write  out  1  single-cycle write pulse
m_address  out  3  0 = status, 1 = message word
m_writedata  out  32  flush word
m_readdata  in  32  slave data, registered, valid exactly 1 cycle after the m_read cycle
bb_x_min  out  11  decoded left edge
bb_y_min  out  11  decoded top edge
bb_x_max  out  11  decoded right edge
bb_y_max  out  11  decoded bottom edge
bb_valid  out  1  1-cycle strobe on coordinate update
bb_present  out  1  1 when bb_x_min <= bb_x_max and bb_y_min <= bb_y_max
msg_count  out  16  messages decoded; wraps at 16'hFFFF -> 0
err_count  out  8  header mismatches; saturates at 8'hFF

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - outputs: m_* = 0; bb_x_min = bb_y_min = 11'h7FF; bb_x_max = bb_y_max = 0; bb_valid = bb_present = 0; counters = 0.
  - state = WAIT, with the wait counter loaded to POLL_INTERVAL-1.
- Bus rules:
  - Each access is exactly one cycle of m_chipselect with m_read or m_write; no waitrequest.
  - At least one idle cycle follows every access. The slave advances its FIFO on a read rising edge, so back-to-back reads are forbidden.
  - m_address and m_writedata are stable during the access cycle.
  - Read data is captured in the cycle after the read pulse, the *_CAP state.
- States:
  - WAIT: counter decrements each cycle. At 0, if enable=1 go to ST_RD; otherwise stay in WAIT and reload the counter.
  - ST_RD: read address 0 -> ST_CAP.
  - ST_CAP: usedw = m_readdata[15:8]. If usedw >= MSG_WORDS go to HD_RD; otherwise go to WAIT and reload the counter.
  - HD_RD: read address 1 -> HD_CAP.
  - HD_CAP:
    - Word == MSG_ID -> TL_RD.
    - Otherwise: err_count++ (saturating) -> FL_WR.
  - FL_WR: write 32'h00000010 (status bit 4, flush) to address 0 -> WAIT.
  - TL_RD: read address 1 -> TL_CAP.
  - TL_CAP: latch x_min = word[26:16] and y_min = word[10:0] into shadow registers -> BR_RD.
  - BR_RD: read address 1 -> BR_CAP.
  - BR_CAP: latch x_max/y_max from word[26:16] and word[10:0] -> PUB.
  - PUB:
    - Copy the shadow registers to the bb_* outputs and update bb_present from the new values on the same edge.
    - bb_valid=1 for this cycle only; msg_count++.
    - Next state: ST_RD if enable=1 (re-poll at once), otherwise WAIT.
- Word field rules: bits [31:27] and [15:11] of coordinate words are ignored. Coordinates are unsigned 11-bit.
- Output timing:
  - bb_* change only in PUB, so a partially read message is never visible.
  - Latency: 8 cycles from the ST_RD pulse to the bb_valid strobe (ST_RD, ST_CAP, HD_RD, HD_CAP, TL_RD, TL_CAP, BR_RD, BR_CAP, then PUB).
- An empty-frame message (x_min=639, x_max=0) publishes normally with bb_present=0.
- enable falling mid-message: the sequence completes through PUB, then the block goes to WAIT. It never abandons a message after HD_RD.
- Reset mid-message: the FSM returns to WAIT. A partial message left in the remote FIFO is caught later by the header check and flush.

Test Plan:
- Status usedw=0 on every poll -> m_read pulses to address 0 only, spaced POLL_INTERVAL+2 cycles apart; no address-1 reads.
- usedw=3; FIFO returns 00524242, {5'b0,11'd100,5'b0,11'd50}, {5'b0,11'd200,5'b0,11'd120} -> bb_valid one cycle with (100,50,200,120), bb_present=1, msg_count=1, exactly 3 address-1 reads each separated by at least one idle cycle.
- Empty-frame message with TL=(639,479) and BR=(0,0) -> bb_valid=1, bb_present=0, msg_count increments.
- Header word 0x12345678 -> err_count=1; next access is a write of 0x10 to address 0; no bb_valid.
- enable dropped at HD_CAP -> message completes with bb_valid, then no further reads while enable=0.
- reset_n asserted low asynchronously at TL_CAP -> all outputs at reset values immediately; after release, the first access is a status poll.
- Drive 256 header mismatches -> err_count holds at 8'hFF.
